uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Next-generation UART receiver: parametrised data width, parity and stop-bit count.
- Baud rate is set at runtime through a divisor port instead of a fixed parameter.
- Output is a valid/ready stream with per-word parity and framing flags, plus overrun and break detection.
- Sits between the board RxD pin and the serial command/weight loader of the neural-network datapath.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2.
- OVERSAMPLE, 16, oversampling ticks per bit; power of 2, at least 8. Illegal values fail elaboration.
- DIV_W, 16, width of baud_div.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- baud_div  in  DIV_W  clk cycles per oversample tick, minus 1.
- rxd  in  1  asynchronous serial input; idles high.
- m_valid  out  1  received word available.
- m_ready  in  1  consumer accepts the word when m_valid && m_ready.
- m_data  out  DATA_BITS  received word.
- m_parity_err  out  1  parity mismatch for m_data; forced 0 when PARITY = 0.
- m_frame_err  out  1  a stop bit was sampled low for m_data.
- overrun  out  1  one-clk pulse: a completed frame was dropped.
- break_det  out  1  one-clk pulse: break condition detected.
- rx_busy  out  1  state other than IDLE.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - Outputs: m_valid, m_data, m_parity_err, m_frame_err, overrun, break_det and rx_busy all go to 0.
  - Internal: state = IDLE, tick counter = 0, both synchroniser flops = 1.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Tick generator:
  - DIV_W-bit counter runs 0..baud_div, then wraps to 0.
  - tick = (cnt == baud_div). baud_div = 0 gives a tick every clk.
  - A baud_div change takes effect on the counter's next comparison. If cnt > new baud_div, the counter wraps through its maximum value (documented; no guard).
- Input conditioning:
  - 2-flop synchroniser on every clk produces rxd_s.
  - Phase counter of log2(OVERSAMPLE) bits advances on each tick; it is held at 0 in IDLE.
  - Each bit's value is the majority of rxd_s sampled at phases OS/2-1, OS/2 and OS/2+1.
  - The bit decision is taken at phase OS/2+1.
- State machine:
  - IDLE: rxd_s = 0 on a tick moves to START with phase 0.
  - START: decision = 1 is a false start, return to IDLE, no output. Decision = 0 realigns the phase and moves to DATA.
  - DATA: shift one bit per bit period; after DATA_BITS bits go to PAR if PARITY != 0, else to STOP.
  - PAR: sample one bit. Odd parity: XOR(data, parity bit) must equal 1. Even parity: it must equal 0.
  - STOP: sample STOP_BITS bits. Frame error if any stop bit is 0.
  - BRKW: wait for rxd_s = 1, then go to IDLE.
- Break:
  - Condition: all data bits, the parity bit (if present) and the first stop bit are all 0.
  - Response: pulse break_det 1 clk after the first stop decision, deliver no word, go to BRKW.
- Delivery:
  - Word is complete at the last stop decision tick; the output register updates on the next clk (latency 1 clk).
  - Two-stop frames complete at the 2nd stop bit, including frames where the 1st stop bit was sampled 0.
- One-entry output register:
  - If it is empty, or m_ready is high in the same cycle the new word lands, load m_data and both flags and set m_valid.
  - Otherwise pulse overrun for 1 clk, discard the new frame, and leave the held word untouched.
- Handshake: m_valid stays high and m_data stays stable until accepted. A simultaneous accept and new word loads the new word with m_valid held at 1.
- Receiver never stalls: the next start bit is searched from IDLE immediately after the stop decision.

Decomposition:
- Package uart_cfg_pkg:
  - Parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN.
  - State enum IDLE, START, DATA, PAR, STOP, BRKW.
  - log2 function.
- Sub-module uart_tick_div: runtime divisor tick generator, reusable by a matching transmitter.

Test Plan:
- Reset and config: DATA_BITS = 8, PARITY = 0, baud_div = 3, OVERSAMPLE = 16 (64 clk/bit). Send 0xA5 -> m_valid with m_data = 0xA5, both error flags 0, 1 clk after the stop decision.
- Even parity: PARITY = 2; send 0x03 with parity bit 0 -> parity_err = 0. Send 0x03 with parity bit 1 -> parity_err = 1, word still delivered.
- Framing and break:
  - Send 0x55 with stop bit 0 -> frame_err = 1.
  - Send all-zero frame with zero stop bit -> break_det pulse, no m_valid. Line held low 5 bit times, then high -> next frame 0x3C received correctly.
- Overrun: m_ready = 0; send 0x11 then 0x22 -> m_data stays 0x11, one overrun pulse. Raise m_ready -> 0x11 accepted, m_valid = 0.
- Glitch and timing:
  - 1-tick low glitch on idle line -> false start, no output.
  - Sender 2% fast at baud_div = 3 -> 8 consecutive bytes correct.
  - rst_n low mid-frame -> all outputs 0, and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver states and a constant log2 used to size the phase counter.
package uart_cfg_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRKW
    } rxState_t;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_tick_div.sv
// Runtime-programmable oversample tick generator: one tick every baudDiv+1 clks.
module uart_tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baudDiv,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // A divisor lowered below the running count lets the counter roll through max.
    assign tick = (cnt == baudDiv);

    always_ff @(posedge clk) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime baud divisor, parity/framing flags,
// break detection and a one-entry valid/ready output register.
module uart_rx_cfg
    import uart_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 rxd,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 rx_busy
);

    localparam int PH_W = log2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_S0  = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_S1  = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0] PH_DEC = PH_W'(OVERSAMPLE / 2 + 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : gBadOversample
        $error("uart_rx_cfg: OVERSAMPLE must be a power of 2 and at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : gBadParity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStopBits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    rxState_t              state, stateNxt;
    logic                  tick;
    logic                  sync1, sync2, rxdS;
    logic [PH_W-1:0]       phase;
    logic                  samp0, samp1;
    logic                  decTick, bitVal;
    logic [3:0]            bitCnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  parBit, parErr, stopErr;
    logic                  parCalc, brkCond, frameErrNow;
    logic                  wordDone, brkHit;

    uart_tick_div #(.DIV_W(DIV_W)) uTickDiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .baudDiv (baud_div),
        .tick    (tick)
    );

    assign rxdS    = sync2;
    assign decTick = tick && (phase == PH_DEC);
    // Third sample is taken live on the decision tick.
    assign bitVal  = (samp0 & samp1) | (samp0 & rxdS) | (samp1 & rxdS);

    assign parCalc     = (PARITY == PAR_EVEN) ? (^shreg ^ bitVal) : ~(^shreg ^ bitVal);
    assign brkCond     = (shreg == '0) && !parBit && !bitVal;
    assign frameErrNow = stopErr | ~bitVal;
    assign rx_busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        wordDone = 1'b0;
        brkHit   = 1'b0;
        case (state)
            IDLE:  if (tick && !rxdS) stateNxt = START;
            START: if (decTick) stateNxt = bitVal ? IDLE : DATA;
            DATA:  if (decTick && bitCnt == 4'(DATA_BITS - 1))
                       stateNxt = (PARITY != PAR_NONE) ? PAR : STOP;
            PAR:   if (decTick) stateNxt = STOP;
            STOP:  if (decTick) begin
                       if (bitCnt == 4'd0 && brkCond) begin
                           brkHit   = 1'b1;
                           stateNxt = BRKW;
                       end else if (bitCnt == 4'(STOP_BITS - 1)) begin
                           wordDone = 1'b1;
                           stateNxt = IDLE;
                       end
                   end
            BRKW:  if (rxdS) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            phase   <= '0;
            samp0   <= 1'b1;
            samp1   <= 1'b1;
            bitCnt  <= '0;
            shreg   <= '0;
            parBit  <= 1'b0;
            parErr  <= 1'b0;
            stopErr <= 1'b0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            // Phase restarts from the start-bit detection tick, so bit centres stay aligned.
            if (state == IDLE || state == BRKW) phase <= '0;
            else if (tick)                      phase <= phase + 1'b1;
            if (tick && phase == PH_S0) samp0 <= rxdS;
            if (tick && phase == PH_S1) samp1 <= rxdS;
            bitCnt <= (stateNxt != state) ? '0 : bitCnt + 4'(decTick);
            if (decTick) begin
                case (state)
                    START: begin
                        parBit  <= 1'b0;
                        parErr  <= 1'b0;
                        stopErr <= 1'b0;
                    end
                    DATA: shreg <= {bitVal, shreg[DATA_BITS-1:1]};
                    PAR: begin
                        parBit <= bitVal;
                        parErr <= parCalc;
                    end
                    STOP:    stopErr <= stopErr | ~bitVal;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_parity_err <= 1'b0;
            m_frame_err  <= 1'b0;
            overrun      <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= brkHit;
            if (wordDone && (!m_valid || m_ready)) begin
                m_valid      <= 1'b1;
                m_data       <= shreg;
                m_parity_err <= (PARITY != PAR_NONE) && parErr;
                m_frame_err  <= frameErrNow;
            end else begin
                if (m_valid && m_ready) m_valid <= 1'b0;
                if (wordDone)           overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1 and 8E1 receivers share one serial line.
module tb_uart_rx_cfg;

    localparam real BT = 640.0;   // one bit = 64 clks at baud_div = 3, OVERSAMPLE = 16
    localparam int  NV = 9;

    typedef struct {
        logic [7:0] data;
        int         dutSel;
        logic       parBit;
        logic       stopBit;
        int         expWords;
        logic [7:0] expData;
        logic       expPerr;
        logic       expFerr;
        int         expBrk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, rxd, rdy0, rdy2;
    logic [15:0] baudDiv;
    logic        v0, pe0, fe0, ov0, bk0, busy0;
    logic        v2, pe2, fe2, ov2, bk2, busy2;
    logic [7:0]  d0, d2;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .baud_div(baudDiv), .rxd(rxd),
        .m_valid(v0), .m_ready(rdy0), .m_data(d0), .m_parity_err(pe0), .m_frame_err(fe0),
        .overrun(ov0), .break_det(bk0), .rx_busy(busy0));

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .baud_div(baudDiv), .rxd(rxd),
        .m_valid(v2), .m_ready(rdy2), .m_data(d2), .m_parity_err(pe2), .m_frame_err(fe2),
        .overrun(ov2), .break_det(bk2), .rx_busy(busy2));

    // Monitors log every accepted word and count one-clk pulses.
    int         cyc = 0;
    logic [9:0] w0 [256];
    logic [9:0] w2 [256];
    int         nW0 = 0, nW2 = 0, nBk0 = 0, nBk2 = 0, nOv0 = 0, nOv2 = 0;
    int         lastRise0 = -1;
    logic       vPrev0 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0 === 1'b1 && rdy0) begin
            w0[nW0[7:0]] <= {pe0, fe0, d0};
            nW0 <= nW0 + 1;
        end
        if (v2 === 1'b1 && rdy2) begin
            w2[nW2[7:0]] <= {pe2, fe2, d2};
            nW2 <= nW2 + 1;
        end
        if (bk0 === 1'b1) nBk0 <= nBk0 + 1;
        if (bk2 === 1'b1) nBk2 <= nBk2 + 1;
        if (ov0 === 1'b1) nOv0 <= nOv0 + 1;
        if (ov2 === 1'b1) nOv2 <= nOv2 + 1;
        if (v0 === 1'b1 && !vPrev0) lastRise0 <= cyc;
        vPrev0 <= (v0 === 1'b1);
    end

    int nChk = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sendFrame(input logic [7:0] d, input bit withPar, input logic pb,
                             input logic sb, input real bt);
        rxd = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            #(bt);
        end
        if (withPar) begin
            rxd = pb;
            #(bt);
        end
        rxd = sb;
        #(bt);
        rxd = 1'b1;
    endtask

    task automatic idle(input real nBits);
        rxd = 1'b1;
        #(nBits * BT);
    endtask

    vec_t       vt [NV];
    int         b0, b2, k0, k2, o0, o2, wc, bc, oc, st, lat;
    logic [9:0] wd;
    logic [7:0] fastData [8];

    initial begin
        vt[0] = '{8'hA5, 0, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0, 0};
        vt[1] = '{8'h55, 0, 1'b0, 1'b0, 1, 8'h55, 1'b0, 1'b1, 0};
        vt[2] = '{8'h00, 0, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1'b0, 0};
        vt[3] = '{8'hFF, 0, 1'b0, 1'b1, 1, 8'hFF, 1'b0, 1'b0, 0};
        vt[4] = '{8'h03, 2, 1'b0, 1'b1, 1, 8'h03, 1'b0, 1'b0, 0};
        vt[5] = '{8'h03, 2, 1'b1, 1'b1, 1, 8'h03, 1'b1, 1'b0, 0};
        vt[6] = '{8'h80, 2, 1'b1, 1'b1, 1, 8'h80, 1'b0, 1'b0, 0};
        vt[7] = '{8'h07, 2, 1'b0, 1'b1, 1, 8'h07, 1'b1, 1'b0, 0};
        vt[8] = '{8'h00, 2, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1};
        fastData = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h5A, 8'hA5, 8'hFF, 8'h10};

        // Reset state
        rst_n = 1'b0; rxd = 1'b1; rdy0 = 1'b1; rdy2 = 1'b1; baudDiv = 16'd3;
        repeat (4) @(negedge clk);
        check("rst m_valid", 32'(v0), 0);
        check("rst m_data", 32'(d0), 0);
        check("rst parity_err", 32'(pe0), 0);
        check("rst frame_err", 32'(fe0), 0);
        check("rst overrun", 32'(ov0), 0);
        check("rst break_det", 32'(bk0), 0);
        check("rst rx_busy", 32'(busy0), 0);
        check("rst rx_busy p2", 32'(busy2), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // First frame: latency from start edge to m_valid, busy mid-frame
        b0 = nW0;
        st = cyc;
        fork
            sendFrame(8'hA5, 1'b0, 1'b0, 1'b1, BT);
            begin
                #(5.0 * BT);
                check("busy mid-frame", 32'(busy0), 1);
            end
        join
        idle(2);
        check("first words", 32'(nW0 - b0), 1);
        check("first data", 32'(w0[b0[7:0]][7:0]), 32'hA5);
        check("first flags", 32'(w0[b0[7:0]][9:8]), 0);
        lat = lastRise0 - st;
        nChk++;
        if (lat < 615 || lat > 626) begin
            nFail++;
            $display("FAIL latency: got %0d clks from start edge, expected 615..626", lat);
        end

        // Table vectors
        for (int i = 0; i < NV; i++) begin
            b0 = nW0; b2 = nW2; k0 = nBk0; k2 = nBk2; o0 = nOv0; o2 = nOv2;
            sendFrame(vt[i].data, vt[i].dutSel == 2, vt[i].parBit, vt[i].stopBit, BT);
            idle(2);
            if (vt[i].dutSel == 0) begin
                wc = nW0 - b0; wd = w0[b0[7:0]]; bc = nBk0 - k0; oc = nOv0 - o0;
            end else begin
                wc = nW2 - b2; wd = w2[b2[7:0]]; bc = nBk2 - k2; oc = nOv2 - o2;
            end
            check($sformatf("vec%0d words", i), 32'(wc), 32'(vt[i].expWords));
            if (vt[i].expWords == 1) begin
                check($sformatf("vec%0d data", i), 32'(wd[7:0]), 32'(vt[i].expData));
                check($sformatf("vec%0d parity_err", i), 32'(wd[9]), 32'(vt[i].expPerr));
                check($sformatf("vec%0d frame_err", i), 32'(wd[8]), 32'(vt[i].expFerr));
            end
            check($sformatf("vec%0d break", i), 32'(bc), 32'(vt[i].expBrk));
            check($sformatf("vec%0d overrun", i), 32'(oc), 0);
        end

        // Break: line low 15 bit times, then recovery with 0x3C
        b0 = nW0; k0 = nBk0;
        rxd = 1'b0;
        #(12.0 * BT);
        check("brk busy in BRKW", 32'(busy0), 1);
        check("brk no word", 32'(nW0 - b0), 0);
        #(3.0 * BT);
        idle(2);
        check("brk pulses", 32'(nBk0 - k0), 1);
        check("brk idle after", 32'(busy0), 0);
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b1, BT);
        idle(2);
        check("brk recover words", 32'(nW0 - b0), 1);
        check("brk recover data", 32'(w0[b0[7:0]]), 32'h03C);

        // Overrun: two frames with m_ready low
        rdy0 = 1'b0;
        b0 = nW0; o0 = nOv0;
        sendFrame(8'h11, 1'b0, 1'b0, 1'b1, BT);
        idle(1);
        sendFrame(8'h22, 1'b0, 1'b0, 1'b1, BT);
        idle(2);
        check("ovr m_valid held", 32'(v0), 1);
        check("ovr m_data held", 32'(d0), 32'h11);
        check("ovr pulses", 32'(nOv0 - o0), 1);
        @(posedge clk); #1 rdy0 = 1'b1;
        @(posedge clk); #1 rdy0 = 1'b0;
        @(negedge clk);
        check("ovr drained m_valid", 32'(v0), 0);
        check("ovr accepted count", 32'(nW0 - b0), 1);
        check("ovr accepted data", 32'(w0[b0[7:0]][7:0]), 32'h11);
        rdy0 = 1'b1;

        // One-tick glitch on idle line
        b0 = nW0; k0 = nBk0;
        rxd = 1'b0;
        #40;
        rxd = 1'b1;
        idle(1.5);
        check("glitch busy", 32'(busy0), 0);
        check("glitch no word", 32'(nW0 - b0), 0);
        check("glitch no break", 32'(nBk0 - k0), 0);

        // Sender 2% fast, 8 back-to-back bytes
        b0 = nW0;
        for (int i = 0; i < 8; i++)
            sendFrame(fastData[i], 1'b0, 1'b0, 1'b1, BT * 0.98);
        idle(2);
        check("fast words", 32'(nW0 - b0), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("fast byte%0d", i), 32'(w0[8'(b0 + i)]), 32'(fastData[i]));

        // Reset mid-frame with a word held in the output register
        rdy0 = 1'b0;
        sendFrame(8'h5A, 1'b0, 1'b0, 1'b1, BT);
        idle(2);
        check("pre-rst held", 32'(d0), 32'h5A);
        b0 = nW0;
        fork
            sendFrame(8'hFF, 1'b0, 1'b0, 1'b1, BT);
            begin
                #(4.5 * BT);
                @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                check("midrst m_valid", 32'(v0), 0);
                check("midrst m_data", 32'(d0), 0);
                check("midrst rx_busy", 32'(busy0), 0);
                check("midrst flags", 32'({pe0, fe0, ov0, bk0}), 0);
                rst_n = 1'b1;
            end
        join
        rdy0 = 1'b1;
        idle(2);
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b1, BT);
        idle(2);
        check("post-rst words", 32'(nW0 - b0), 1);
        check("post-rst data", 32'(w0[b0[7:0]]), 32'h03C);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
